rvfi_commit_tracker: RTL and testbench
======================================

# rvfi_commit_tracker

Parametrised retirement tracker between the mp3 writeback stage and the RVFI monitor. It turns per-lane writeback-valid qualifiers into registered commit strobes with monotonically increasing instruction order numbers. It detects halt as a committed self-branch repeated a configurable number of times, and flags a hung core when nothing commits for too long. It supersedes the hardwired always-commit, single-lane order counter and single-compare halt in the mp3 bench.

## Interface
Parameters:
- NUM_CH, 2 — commit lanes per cycle (1..4); lane 0 is oldest in program order.
- XLEN, 32 — PC width.
- ORDER_W, 64 — order counter width.
- HALT_REPEAT, 2 — consecutive self-loop commits required to declare halt (≥1).
- TIMEOUT, 1024 — cycles without any commit before `hung` is raised (≥2).

Ports:
- clk  in  1  clock; single clock domain, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- wb_valid  in  NUM_CH  lane i retires an instruction this cycle.
- wb_pc  in  NUM_CH×XLEN  PC of retiring instruction, per lane.
- wb_next_pc  in  NUM_CH×XLEN  next PC of retiring instruction, per lane.
- commit  out  NUM_CH  registered per-lane commit strobe.
- order  out  NUM_CH×ORDER_W  order number of the instruction committed on lane i.
- retired  out  ORDER_W  total instructions committed since reset.
- halt  out  1  sticky; halt detected.
- hung  out  1  sticky; commit timeout expired.

## Operation
- FSM states: RUN, HALTED, HUNG. Reset enters RUN.
- RUN:
  - `commit[i] <= wb_valid[i]`.
  - `order[i] <= retired + popcount(wb_valid[i-1:0])`, so non-contiguous valid lanes still get dense, gap-free order numbers in lane order.
  - `retired <= retired + popcount(wb_valid)`.
- Self-loop: a valid lane with `wb_pc == wb_next_pc`.
  - Scan valid lanes from lane 0 upward. A self-loop increments `loop_cnt`; any valid non-self-loop lane clears it.
  - The order within a cycle matters: a self-loop after a clearing lane in the same cycle counts from 0.
  - Cycles with no valid lane leave `loop_cnt` unchanged.
  - When `loop_cnt` reaches HALT_REPEAT, go to HALTED.
  - Lanes in that cycle up to and including the triggering lane commit normally. Younger lanes are suppressed (no commit, no order increment).
- Idle tracking: `idle_cnt` clears on any cycle with a valid lane and increments otherwise. When it reaches TIMEOUT, go to HUNG.
- HALTED and HUNG: absorbing until `rst`. `commit` is all 0; `order` and `retired` hold their last values. `halt` is 1 only in HALTED; `hung` is 1 only in HUNG.
- If the halt and timeout conditions occur in the same cycle (impossible by construction, since halt needs a valid lane), halt wins.
- `loop_cnt` saturates at HALT_REPEAT. `idle_cnt` saturates at TIMEOUT.
- `retired` and `order` wrap modulo 2^ORDER_W; no overflow flag.

## Timing
- Reset values: `commit` = 0, `order` = 0 on all lanes, `retired` = 0, `halt` = 0, `hung` = 0, `loop_cnt` = 0, `idle_cnt` = 0, state = RUN.
- Latency: one cycle from `wb_valid` to `commit`/`order`. `halt` asserts in the same cycle as the triggering commit strobe.
- `hung` asserts on the edge where `idle_cnt` would reach TIMEOUT, i.e. TIMEOUT idle cycles after the last valid cycle.
- `rst` asserted mid-run: all state returns to reset values on that edge; inputs are ignored in that cycle.
- No backpressure: the block accepts `wb_valid` every cycle.

## Structure
- Shared package `rvfi_pkg`:
  - `tracker_state_t` enum {RUN, HALTED, HUNG}.
  - Lane-vector typedefs.
- One sub-module, `lane_prefix_count`: combinational exclusive prefix popcount over NUM_CH bits, returning per-lane offsets and the total.
- Top level holds the FSM, counters and output registers.
- The mp3 bench drives `wb_valid` from the writeback pipeline register valid and stall qualifiers, and connects `rvfi.commit`, `rvfi.order` and `rvfi.halt` to this block.

## Test plan
Default parameters (NUM_CH=2, HALT_REPEAT=2, TIMEOUT=1024) unless stated.
- Reset then dual commit: `wb_valid`=11 for 3 cycles → `commit`=11 one cycle later each time; orders (0,1), (2,3), (4,5); `retired`=6.
- Sparse lanes: `wb_valid`=10 then 01 → lane 1 gets order 0, then lane 0 gets order 1; `retired`=2.
- Halt:
  - Lane 0 self-loop at pc 0x60 in two consecutive cycles, lane 1 valid and not a self-loop in the second cycle → `halt`=1 with lane 0 commit in the second cycle; lane 1 suppressed.
  - Afterwards, `commit` stays 0 and `retired` stays frozen.
- Loop reset: self-loop, then a normal commit, then a self-loop → `halt` stays 0. With HALT_REPEAT=1, a single self-loop → `halt`=1.
- Timeout: with TIMEOUT=8, one commit then `wb_valid`=00 → `hung`=1 exactly 8 cycles after the last valid cycle; later `wb_valid`=11 → no commit.
- Reset mid-run: `rst` pulsed after `retired`=5 with `halt`=1 → next cycle all outputs 0, state RUN; the next commit gets order 0.

Source files
------------

// File: rtl/rvfi_pkg.sv
// Shared types for the RVFI retirement tracker: FSM state and lane-vector types.
package rvfi_pkg;

   localparam int MAX_CH = 4;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      HUNG   = 2'd2
   } tracker_state_t;

   typedef logic [MAX_CH-1:0] lane_mask_t;
   // Wide enough for a popcount of up to MAX_CH lanes.
   typedef logic [2:0]        lane_cnt_t;

endpackage

// File: rtl/lane_prefix_count.sv
// Exclusive prefix popcount over a lane mask: offset[i] counts set lanes below i.
module lane_prefix_count
   import rvfi_pkg::*;
#(
   parameter int NUM_CH = 2
) (
   input  logic      [NUM_CH-1:0] mask,
   output lane_cnt_t [NUM_CH-1:0] offset,
   output lane_cnt_t              total
);

   lane_cnt_t acc;

   always_comb begin
      acc    = '0;
      offset = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         offset[i] = acc;
         acc       = acc + lane_cnt_t'(mask[i]);
      end
      total = acc;
   end

endmodule

// File: rtl/rvfi_commit_tracker.sv
// Retirement tracker: registers commit strobes and dense order numbers, and
// detects halt (repeated committed self-loop) and hung core (commit timeout).
//
// state  | meaning
// RUN    | commits flow through, counters advance
// HALTED | self-loop seen HALT_REPEAT times; outputs frozen until rst
// HUNG   | TIMEOUT cycles without a commit; outputs frozen until rst
module rvfi_commit_tracker
   import rvfi_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int XLEN        = 32,
   parameter int ORDER_W     = 64,
   parameter int HALT_REPEAT = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_CH-1:0]                wb_valid,
   input  logic [NUM_CH-1:0][XLEN-1:0]      wb_pc,
   input  logic [NUM_CH-1:0][XLEN-1:0]      wb_next_pc,
   output logic [NUM_CH-1:0]                commit,
   output logic [NUM_CH-1:0][ORDER_W-1:0]   order,
   output logic [ORDER_W-1:0]               retired,
   output logic                             halt,
   output logic                             hung
);

   localparam int LOOP_W = $clog2(HALT_REPEAT + 1);
   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam logic [LOOP_W-1:0] LOOP_MAX = LOOP_W'(HALT_REPEAT);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

   tracker_state_t            state;
   logic [LOOP_W-1:0]         loop_cnt;
   logic [LOOP_W-1:0]         loop_nxt;
   logic [IDLE_W-1:0]         idle_cnt;
   logic [IDLE_W-1:0]         idle_nxt;
   logic [NUM_CH-1:0]         eff_valid;
   logic                      halt_hit;
   lane_cnt_t [NUM_CH-1:0]    offset;
   lane_cnt_t                 total;

   // Walk lanes oldest first; once the halt trigger is hit, younger lanes drop out.
   always_comb begin
      loop_nxt  = loop_cnt;
      halt_hit  = 1'b0;
      eff_valid = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (wb_valid[i] && !halt_hit) begin
            eff_valid[i] = 1'b1;
            if (wb_pc[i] == wb_next_pc[i]) begin
               if (loop_nxt != LOOP_MAX)
                  loop_nxt = loop_nxt + 1'b1;
            end else begin
               loop_nxt = '0;
            end
            if (loop_nxt == LOOP_MAX)
               halt_hit = 1'b1;
         end
      end
   end

   always_comb begin
      if (|wb_valid)
         idle_nxt = '0;
      else if (idle_cnt == IDLE_MAX)
         idle_nxt = idle_cnt;
      else
         idle_nxt = idle_cnt + 1'b1;
   end

   lane_prefix_count #(
      .NUM_CH (NUM_CH)
   ) u_prefix (
      .mask   (eff_valid),
      .offset (offset),
      .total  (total)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         commit   <= '0;
         order    <= '0;
         retired  <= '0;
         halt     <= 1'b0;
         hung     <= 1'b0;
         loop_cnt <= '0;
         idle_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               commit <= eff_valid;
               for (int i = 0; i < NUM_CH; i++)
                  order[i] <= retired + ORDER_W'(offset[i]);
               retired  <= retired + ORDER_W'(total);
               loop_cnt <= loop_nxt;
               idle_cnt <= idle_nxt;
               // halt needs a valid lane, so it can never race the timeout
               if (halt_hit) begin
                  state <= HALTED;
                  halt  <= 1'b1;
               end else if (idle_nxt == IDLE_MAX) begin
                  state <= HUNG;
                  hung  <= 1'b1;
               end
            end
            default: begin
               commit <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Directed bench for rvfi_commit_tracker: three parameterisations share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_rvfi_commit_tracker;

   localparam int NI = 3;
   localparam int HR [NI] = '{2, 1, 2};
   localparam int TO [NI] = '{1024, 1024, 8};

   logic                  clk;
   logic                  rst;
   logic [1:0]            wb_valid;
   logic [1:0][31:0]      wb_pc;
   logic [1:0][31:0]      wb_next_pc;
   logic [31:0]           pc_seed;

   logic [NI-1:0][1:0]        commit_o;
   logic [NI-1:0][1:0][63:0]  order_o;
   logic [NI-1:0][63:0]       retired_o;
   logic [NI-1:0]             halt_o;
   logic [NI-1:0]             hung_o;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state, per instance
   int              m_state  [NI];
   longint unsigned m_ret    [NI];
   int              m_loop   [NI];
   int              m_idle   [NI];
   logic [1:0]      m_commit [NI];
   logic [63:0]     m_order  [NI][2];

   rvfi_commit_tracker #(.NUM_CH(2), .XLEN(32), .ORDER_W(64), .HALT_REPEAT(2), .TIMEOUT(1024)) dut_a (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_next_pc(wb_next_pc),
      .commit(commit_o[0]), .order(order_o[0]), .retired(retired_o[0]), .halt(halt_o[0]), .hung(hung_o[0]));

   rvfi_commit_tracker #(.NUM_CH(2), .XLEN(32), .ORDER_W(64), .HALT_REPEAT(1), .TIMEOUT(1024)) dut_b (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_next_pc(wb_next_pc),
      .commit(commit_o[1]), .order(order_o[1]), .retired(retired_o[1]), .halt(halt_o[1]), .hung(hung_o[1]));

   rvfi_commit_tracker #(.NUM_CH(2), .XLEN(32), .ORDER_W(64), .HALT_REPEAT(2), .TIMEOUT(8)) dut_c (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_next_pc(wb_next_pc),
      .commit(commit_o[2]), .order(order_o[2]), .retired(retired_o[2]), .halt(halt_o[2]), .hung(hung_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_step(input int k);
      bit stop;
      int n;
      if (rst) begin
         m_state[k] = 0; m_ret[k] = 0; m_loop[k] = 0; m_idle[k] = 0;
         m_commit[k] = 2'b00; m_order[k][0] = '0; m_order[k][1] = '0;
      end else if (m_state[k] == 0) begin
         stop = 1'b0;
         n    = 0;
         for (int l = 0; l < 2; l++) begin
            m_order[k][l] = m_ret[k] + 64'(n);
            if (wb_valid[l] && !stop) begin
               m_commit[k][l] = 1'b1;
               n++;
               if (wb_pc[l] == wb_next_pc[l]) begin
                  if (m_loop[k] < HR[k]) m_loop[k]++;
               end else begin
                  m_loop[k] = 0;
               end
               if (m_loop[k] == HR[k]) stop = 1'b1;
            end else begin
               m_commit[k][l] = 1'b0;
            end
         end
         m_ret[k] = m_ret[k] + 64'(n);
         if (wb_valid != 2'b00) m_idle[k] = 0;
         else if (m_idle[k] < TO[k]) m_idle[k]++;
         if (stop) m_state[k] = 1;
         else if (m_idle[k] == TO[k]) m_state[k] = 2;
      end else begin
         m_commit[k] = 2'b00;
      end
   endtask

   task automatic cmp(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d got %h want %h at %0t", name, k, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) model_step(k);
      #1;
      for (int k = 0; k < NI; k++) begin
         cmp("commit",  k, 64'(commit_o[k]), 64'(m_commit[k]));
         cmp("order0",  k, order_o[k][0], m_order[k][0]);
         cmp("order1",  k, order_o[k][1], m_order[k][1]);
         cmp("retired", k, retired_o[k], m_ret[k]);
         cmp("halt",    k, 64'(halt_o[k]), 64'(m_state[k] == 1));
         cmp("hung",    k, 64'(hung_o[k]), 64'(m_state[k] == 2));
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL lit_%s got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; s0/s1 make that lane a self-loop at 0x60.
   task automatic st(input logic [1:0] v, input logic s0, input logic s1, input logic r = 1'b0);
      rst      = r;
      wb_valid = v;
      pc_seed  = pc_seed + 32'd16;
      wb_pc[0]      = s0 ? 32'h60 : pc_seed;
      wb_next_pc[0] = s0 ? 32'h60 : pc_seed + 32'd4;
      wb_pc[1]      = s1 ? 32'h60 : pc_seed + 32'd4;
      wb_next_pc[1] = s1 ? 32'h60 : pc_seed + 32'd8;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; wb_valid = '0; wb_pc = '0; wb_next_pc = '0; pc_seed = 32'h100;
      st(2'b00, 0, 0, 1);
      st(2'b00, 0, 0, 1);
      chk("rst_commit",  64'(commit_o[0]), 64'd0);
      chk("rst_retired", retired_o[0], 64'd0);
      chk("rst_halt",    64'(halt_o[0]), 64'd0);
      chk("rst_hung",    64'(hung_o[0]), 64'd0);

      // dual commit
      st(2'b11, 0, 0);
      chk("dual_commit", 64'(commit_o[0]), 64'd3);
      chk("dual_o0", order_o[0][0], 64'd0);
      chk("dual_o1", order_o[0][1], 64'd1);
      st(2'b11, 0, 0);
      st(2'b11, 0, 0);
      chk("dual_o0_3", order_o[0][0], 64'd4);
      chk("dual_o1_3", order_o[0][1], 64'd5);
      chk("dual_ret",  retired_o[0], 64'd6);

      // sparse lanes
      st(2'b00, 0, 0, 1);
      st(2'b10, 0, 0);
      chk("sparse_commit", 64'(commit_o[0]), 64'd2);
      chk("sparse_o1",     order_o[0][1], 64'd0);
      st(2'b01, 0, 0);
      chk("sparse_o0",  order_o[0][0], 64'd1);
      chk("sparse_ret", retired_o[0], 64'd2);

      // halt, then reset mid-run
      st(2'b00, 0, 0, 1);
      st(2'b11, 0, 0);
      st(2'b10, 0, 0);
      st(2'b01, 1, 0);
      chk("halt_early", 64'(halt_o[0]), 64'd0);
      st(2'b11, 1, 0);
      chk("halt_set",    64'(halt_o[0]), 64'd1);
      chk("halt_commit", 64'(commit_o[0]), 64'd1);
      chk("halt_ret",    retired_o[0], 64'd5);
      st(2'b11, 0, 0);
      chk("halted_commit", 64'(commit_o[0]), 64'd0);
      chk("halted_ret",    retired_o[0], 64'd5);
      st(2'b11, 0, 0, 1);
      chk("mid_rst_halt", 64'(halt_o[0]), 64'd0);
      chk("mid_rst_ret",  retired_o[0], 64'd0);
      chk("mid_rst_o1",   order_o[0][1], 64'd0);
      st(2'b11, 0, 0);
      chk("post_rst_o0", order_o[0][0], 64'd0);
      chk("post_rst_o1", order_o[0][1], 64'd1);

      // loop counter clearing, including order within one cycle
      st(2'b00, 0, 0, 1);
      st(2'b01, 1, 0);
      chk("hr1_halt", 64'(halt_o[1]), 64'd1);
      chk("hr2_no_halt", 64'(halt_o[0]), 64'd0);
      st(2'b01, 0, 0);
      st(2'b01, 1, 0);
      chk("loop_clr_halt", 64'(halt_o[0]), 64'd0);
      st(2'b11, 0, 1);
      chk("inlane_clr_halt", 64'(halt_o[0]), 64'd0);
      st(2'b11, 1, 1);
      chk("inlane_halt",   64'(halt_o[0]), 64'd1);
      chk("inlane_commit", 64'(commit_o[0]), 64'd1);

      // timeout on the TIMEOUT=8 instance
      st(2'b00, 0, 0, 1);
      st(2'b11, 0, 0);
      for (int i = 0; i < 7; i++) st(2'b00, 0, 0);
      chk("hung_before", 64'(hung_o[2]), 64'd0);
      st(2'b00, 0, 0);
      chk("hung_at8",  64'(hung_o[2]), 64'd1);
      chk("hung_long", 64'(hung_o[0]), 64'd0);
      st(2'b11, 0, 0);
      chk("hung_commit", 64'(commit_o[2]), 64'd0);
      chk("hung_ret",    retired_o[2], 64'd2);

      st(2'b00, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
